mmio_map_v2: RTL and testbench
==============================

Name: mmio_map_v2

Overview:
- Parametrised memory-mapped I/O decoder between the processor data-memory port, data RAM and peripherals.
- Low half of the address space goes to RAM; high half is an 8-register peripheral window.
- Peripheral window provides:
  - button synchronisation with sticky edge capture;
  - SD command issue with a valid/ready handshake;
  - a buffered SD response FIFO with overflow tracking.

Parameters:
- ADDR_W, 12, data-memory address width; addr[ADDR_W-1] selects the peripheral window.
- DATA_W, 32, data bus width; minimum 32.
- NUM_BTN, 5, number of button inputs; 1..16.
- CMD_W, 48, SD command width; 33..64, split LO[31:0] / HI[CMD_W-33:0].
- RESP_DEPTH, 8, SD response FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- addr  in  ADDR_W  data-memory address
- dataIn  in  DATA_W  store data
- dataOut  out  DATA_W  load data, combinational from addr and state
- writeEnable  in  1  store strobe
- readEnable  in  1  load strobe; used only for the FIFO pop side effect
- RAM_out  in  DATA_W  RAM read data
- RAM_write  out  1  writeEnable && !addr[ADDR_W-1]
- BTN  in  NUM_BTN  asynchronous button levels
- SD_resp_valid  in  1  one-cycle pulse, response byte present
- SD_resp_data  in  8  response byte
- SD_cmd  out  CMD_W  command register contents
- SD_cmd_valid  out  1  command request
- SD_cmd_ready  in  1  controller accepts command

Behaviour:
- Reset: all registers clear asynchronously on resetn low; no output glitches high during reset.
  - SD_cmd=0, SD_cmd_valid=0.
  - Button synchronisers and edge register=0.
  - FIFO empty, overflow=0.
- Register index is addr[2:0] when addr[ADDR_W-1]=1; otherwise dataOut=RAM_out. Unlisted bits read 0.
  - 0 BTN_STATE R: synchronised buttons. Two-flop synchroniser, so 2-cycle latency from BTN.
  - 1 BTN_EDGE R/W1C: bit i set on a 0->1 transition of synchronised bit i. Writing 1 clears. Set wins over a same-cycle clear.
  - 2 SD_RESP R: {empty_n at bit31, 23'b0, head byte}. When empty, reads 0x000000FF.
    - Pop occurs on the clk edge where readEnable=1, addr selects reg 2 and the FIFO is non-empty.
    - Pop on empty: no effect.
  - 3 SD_STATUS R: bit0 SD_cmd_valid (busy), bit1 overflow sticky, bits[15:8] FIFO count.
  - 4 SD_CMD_LO R/W: SD_cmd[31:0].
  - 5 SD_CMD_HI R/W: bits[CMD_W-33:0] map to SD_cmd[CMD_W-1:32]. Bit31 reads SD_cmd_valid.
    - Write with dataIn[31]=1 and SD_cmd_valid=0: sets SD_cmd_valid next cycle.
  - 6 CONTROL W: bit0=1 clears overflow; bit1=1 flushes the FIFO (count=0). Reads 0.
  - 7 reserved: reads 0, writes ignored.
- Command handshake:
  - SD_cmd_valid holds until the first edge with SD_cmd_ready=1, then clears.
  - While SD_cmd_valid=1, writes to regs 4/5 are ignored and the start bit is ignored; SD_cmd stays stable.
  - Write with start and SD_cmd_ready=1 on the same edge: the command is latched and valid rises; acceptance is counted on a later cycle only.
- FIFO:
  - Push on SD_resp_valid.
  - Push when full: byte dropped, overflow sets.
  - Simultaneous push and pop when full: both occur, no overflow.
  - Simultaneous push and pop when empty: push only.
  - Flush and push on the same edge: flush wins; byte dropped, no overflow.
  - Pointers wrap modulo RESP_DEPTH; count ranges 0..RESP_DEPTH.
- Peripheral-window writes never assert RAM_write. RAM-space reads and writes have no peripheral side effects.
- resetn asserted mid-handshake: SD_cmd_valid drops immediately and the pending command is discarded.

Test Plan:
- Reset, then idle: read regs 0..7 -> 0, 0, 0x000000FF, 0, 0, 0, 0, 0; SD_cmd_valid=0; RAM reads pass RAM_out=0x12345678.
- BTN=5'b00100 at cycle 10:
  - reg0 reads 0x4 from cycle 12; reg1 reads 0x4 and stays 0x4 after BTN returns to 0.
  - Write reg1=0x4 -> reads 0.
  - Edge arriving on the same cycle as the clear -> stays 0x4.
- Write reg4=0xDEADBEEF, then reg5=0x80001234:
  - SD_cmd=0x1234DEADBEEF and SD_cmd_valid=1.
  - Hold SD_cmd_ready=0 for 5 cycles, writing reg4=0 meanwhile: SD_cmd unchanged.
  - Raise ready -> valid clears next cycle; reg3 bit0=0.
- Push 0x01..0x09 with RESP_DEPTH=8:
  - reg3 shows count=8 and overflow=1.
  - Pops return 0x80000001..0x80000008, then 0x000000FF.
  - Write reg6=1 -> overflow=0.
- FIFO full, simultaneous push 0xAA and pop -> pop returns the oldest byte; count stays 8; overflow stays 0.
- Valid pending, resetn pulsed low mid-cycle -> SD_cmd_valid=0 and SD_cmd=0 immediately, FIFO empty.

Source files
------------

// File: rtl/mmio_map_v2.sv
// mmio_map_v2 -- data-memory address decoder for RAM and a small peripheral window.
//
// Purpose:
//   The low half of the data address space passes straight through to RAM.
//   The high half (addr[ADDR_W-1] = 1) is an 8-register peripheral window,
//   indexed by addr[2:0]:
//     0 BTN_STATE   R     synchronised button levels
//     1 BTN_EDGE    R/W1C sticky rising-edge flags
//     2 SD_RESP     R     {not_empty, 23'b0, head byte}; 0x000000FF when empty;
//                         a load (readEnable) pops the FIFO
//     3 SD_STATUS   R     bit0 command busy, bit1 overflow, bits[15:8] count
//     4 SD_CMD_LO   R/W   SD_cmd[31:0]
//     5 SD_CMD_HI   R/W   SD_cmd[CMD_W-1:32]; bit31 reads busy, writing 1 starts
//     6 CONTROL     W     bit0 clears overflow, bit1 flushes the FIFO
//     7 reserved
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   addr, dataIn, dataOut       processor data-memory port (dataOut is combinational)
//   writeEnable, readEnable     store / load strobes
//   RAM_out, RAM_write          data RAM read data and write strobe
//   BTN                         asynchronous button inputs
//   SD_resp_valid, SD_resp_data response byte stream from the SD controller
//   SD_cmd, SD_cmd_valid, SD_cmd_ready  command valid/ready handshake
module mmio_map_v2 #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int NUM_BTN    = 5,
    parameter int CMD_W      = 48,
    parameter int RESP_DEPTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   dataIn,
    output logic [DATA_W-1:0]   dataOut,
    input  logic                writeEnable,
    input  logic                readEnable,
    input  logic [DATA_W-1:0]   RAM_out,
    output logic                RAM_write,
    input  logic [NUM_BTN-1:0]  BTN,
    input  logic                SD_resp_valid,
    input  logic [7:0]          SD_resp_data,
    output logic [CMD_W-1:0]    SD_cmd,
    output logic                SD_cmd_valid,
    input  logic                SD_cmd_ready
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int HI_W  = CMD_W - 32;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       periph_sel;
    logic [2:0] reg_idx;
    logic [7:0] wr_sel;

    assign periph_sel = addr[ADDR_W-1];
    assign reg_idx    = addr[2:0];
    assign RAM_write  = writeEnable & ~periph_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_wr_sel
            assign wr_sel[gi] = writeEnable & periph_sel & (reg_idx == 3'(gi));
        end
    endgenerate

    // Only the register index bits of a peripheral address are decoded.
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_W-2:3];

    generate
        if (DATA_W > 32) begin : g_wide_data
            logic unused_data;
            assign unused_data = ^dataIn[DATA_W-1:32];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_meta_q, btn_meta_d;
    logic [NUM_BTN-1:0] btn_sync_q, btn_sync_d;
    logic [NUM_BTN-1:0] btn_prev_q, btn_prev_d;
    logic [NUM_BTN-1:0] btn_edge_q, btn_edge_d;
    logic [NUM_BTN-1:0] btn_rise;

    logic [7:0]         resp_mem_q [RESP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;

    // Rising edge of the synchronised level, seen one stage after the synchroniser
    // so that only settled values feed the sticky flags.
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn_rise
            assign btn_rise[gi] = btn_sync_q[gi] & ~btn_prev_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic fifo_empty, fifo_full, fifo_flush, fifo_pop, fifo_push, ovf_set, ovf_clr;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(RESP_DEPTH));
        fifo_flush = wr_sel[6] & dataIn[1];
        ovf_clr    = wr_sel[6] & dataIn[0];
        // A flush overrides everything on that edge, including an arriving byte.
        fifo_pop   = readEnable & periph_sel & (reg_idx == 3'd2) & ~fifo_empty & ~fifo_flush;
        // When full, a same-edge pop frees the slot the new byte lands in.
        fifo_push  = SD_resp_valid & ~fifo_flush & (~fifo_full | fifo_pop);
        ovf_set    = SD_resp_valid & ~fifo_flush & fifo_full & ~fifo_pop;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        btn_meta_d = BTN;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
        // Set has priority over a write-one-to-clear on the same edge.
        btn_edge_d = btn_edge_q;
        if (wr_sel[1]) begin
            btn_edge_d = btn_edge_d & ~dataIn[NUM_BTN-1:0];
        end
        btn_edge_d = btn_edge_d | btn_rise;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        // A new overflow event wins over a same-edge clear so it is never lost.
        overflow_d = (overflow_q & ~ovf_clr) | ovf_set;

        // The command register is frozen while a request is outstanding.
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        if (cmd_valid_q) begin
            if (SD_cmd_ready) begin
                cmd_valid_d = 1'b0;
            end
        end else begin
            if (wr_sel[4]) begin
                cmd_d[31:0] = dataIn[31:0];
            end
            if (wr_sel[5]) begin
                cmd_d[CMD_W-1:32] = dataIn[HI_W-1:0];
                if (dataIn[31]) begin
                    cmd_valid_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            btn_prev_q  <= '0;
            btn_edge_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            btn_prev_q  <= btn_prev_d;
            btn_edge_q  <= btn_edge_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    // FIFO storage needs no reset: a slot is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            resp_mem_q[wr_ptr_q] <= SD_resp_data;
        end
    end

    assign SD_cmd       = cmd_q;
    assign SD_cmd_valid = cmd_valid_q;

    // ------------------------------------------------------------------
    // Read mux (combinational from addr and state)
    // ------------------------------------------------------------------
    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        case (reg_idx)
            3'd0: rd_word[NUM_BTN-1:0] = btn_sync_q;
            3'd1: rd_word[NUM_BTN-1:0] = btn_edge_q;
            3'd2: begin
                if (fifo_empty) begin
                    rd_word = 32'h0000_00FF;
                end else begin
                    rd_word = {1'b1, 23'b0, resp_mem_q[rd_ptr_q]};
                end
            end
            3'd3: begin
                rd_word[0]    = cmd_valid_q;
                rd_word[1]    = overflow_q;
                rd_word[15:8] = 8'(count_q);
            end
            3'd4: rd_word = cmd_q[31:0];
            3'd5: begin
                rd_word[HI_W-1:0] = cmd_q[CMD_W-1:32];
                rd_word[31]       = cmd_valid_q;
            end
            default: rd_word = '0;
        endcase
    end

    assign dataOut = periph_sel ? DATA_W'(rd_word) : RAM_out;

endmodule

// File: tb/tb_mmio_map_v2.sv
module tb_mmio_map_v2;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int NUM_BTN    = 5;
    localparam int CMD_W      = 48;
    localparam int RESP_DEPTH = 8;

    logic                clk = 1'b0;
    logic                resetn;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   dataIn;
    logic [DATA_W-1:0]   dataOut;
    logic                writeEnable;
    logic                readEnable;
    logic [DATA_W-1:0]   RAM_out;
    logic                RAM_write;
    logic [NUM_BTN-1:0]  BTN;
    logic                SD_resp_valid;
    logic [7:0]          SD_resp_data;
    logic [CMD_W-1:0]    SD_cmd;
    logic                SD_cmd_valid;
    logic                SD_cmd_ready;

    always #5 clk = ~clk;

    mmio_map_v2 #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BTN(NUM_BTN),
        .CMD_W(CMD_W), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .dataIn(dataIn), .dataOut(dataOut),
        .writeEnable(writeEnable), .readEnable(readEnable), .RAM_out(RAM_out),
        .RAM_write(RAM_write), .BTN(BTN), .SD_resp_valid(SD_resp_valid),
        .SD_resp_data(SD_resp_data), .SD_cmd(SD_cmd), .SD_cmd_valid(SD_cmd_valid),
        .SD_cmd_ready(SD_cmd_ready)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0]       v;
        logic [ADDR_W-1:0] a;
    } rd_t;

    rd_t                exp_q[$];     // expected load data, in issue order
    logic [CMD_W-1:0]   cmd_exp[$];   // commands expected to be accepted
    logic [NUM_BTN-1:0] hist[$];      // BTN value seen at each of the last 3 edges
    logic [NUM_BTN-1:0] m_edge;
    logic [7:0]         m_fifo[$];
    bit                 m_ovf;
    bit                 m_valid;
    logic [CMD_W-1:0]   m_cmd;

    // DUT-visible state for the cycle in progress (model after the last edge)
    bit                 cur_valid = 1'b0;
    logic [CMD_W-1:0]   cur_cmd   = '0;
    bit                 done      = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [ADDR_W-1:0] pa(input int idx);
        return {1'b1, 8'h00, 3'(idx)};
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back('0);
        m_edge = '0;
        m_fifo.delete();
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_cmd   = '0;
        cmd_exp.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        if (!a[ADDR_W-1]) return RAM_out;
        case (a[2:0])
            3'd0: return 32'(hist[$-1]);
            3'd1: return 32'(m_edge);
            3'd2: return (m_fifo.size() != 0) ? {1'b1, 23'b0, m_fifo[0]} : 32'h0000_00FF;
            3'd3: return {16'b0, 8'(m_fifo.size()), 6'b0, m_ovf, m_valid};
            3'd4: return m_cmd[31:0];
            3'd5: return {m_valid, 15'b0, m_cmd[CMD_W-1:32]};
            default: return 32'h0;
        endcase
    endfunction

    // Apply the effect of the coming clock edge to the model, from current inputs.
    task automatic model_edge();
        bit               per = addr[ADDR_W-1];
        logic [2:0]       idx = addr[2:0];
        bit               wr_p = writeEnable && per;
        bit               rd_p = readEnable && per;
        logic [NUM_BTN-1:0] rise;
        bit               ovf_set = 1'b0;

        rise = hist[$-1] & ~hist[$-2];
        if (wr_p && idx == 3'd1) m_edge = m_edge & ~dataIn[NUM_BTN-1:0];
        m_edge = m_edge | rise;
        hist.push_back(BTN);
        void'(hist.pop_front());

        if (wr_p && idx == 3'd6 && dataIn[1]) begin
            m_fifo.delete();
        end else begin
            if (rd_p && idx == 3'd2 && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (SD_resp_valid) begin
                if (m_fifo.size() < RESP_DEPTH) m_fifo.push_back(SD_resp_data);
                else ovf_set = 1'b1;
            end
        end
        m_ovf = (m_ovf && !(wr_p && idx == 3'd6 && dataIn[0])) || ovf_set;

        if (m_valid) begin
            if (SD_cmd_ready) m_valid = 1'b0;
        end else begin
            if (wr_p && idx == 3'd4) m_cmd[31:0] = dataIn[31:0];
            if (wr_p && idx == 3'd5) begin
                m_cmd[CMD_W-1:32] = dataIn[CMD_W-33:0];
                if (dataIn[31]) begin
                    m_valid = 1'b1;
                    cmd_exp.push_back(m_cmd);
                end
            end
        end
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic cycle(input bit use_c, input logic [31:0] c);
        rd_t e;
        if (readEnable) begin
            e.v = use_c ? c : model_read(addr);
            e.a = addr;
            exp_q.push_back(e);
        end
        model_edge();
        @(posedge clk);
        #1;
        cur_valid = m_valid;
        cur_cmd   = m_cmd;
    endtask

    task automatic idle(input int n);
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        repeat (n) cycle(1'b0, 32'h0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        addr = a; dataIn = d; writeEnable = 1'b1; readEnable = 1'b0;
        cycle(1'b0, 32'h0);
        writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        addr = a; readEnable = 1'b1; writeEnable = 1'b0;
        cycle(1'b0, 32'h0);
        readEnable = 1'b0;
    endtask

    task automatic rdc(input logic [ADDR_W-1:0] a, input logic [31:0] e);
        addr = a; readEnable = 1'b1; writeEnable = 1'b0;
        cycle(1'b1, e);
        readEnable = 1'b0;
    endtask

    // Reset pulse that starts mid-cycle, away from any clock edge.
    task automatic do_reset();
        #2;
        writeEnable = 1'b0; readEnable = 1'b0; SD_resp_valid = 1'b0;
        resetn    = 1'b0;
        model_reset();
        cur_valid = 1'b0;
        cur_cmd   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        rd_t e;
        logic [CMD_W-1:0] c;
        forever begin
            @(negedge clk);
            if (done) begin
                n_checks++;
                if (exp_q.size() != 0 || cmd_exp.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain: pending reads %0d, pending commands %0d, required 0 and 0",
                             exp_q.size(), cmd_exp.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
            n_checks++;
            if (RAM_write !== (writeEnable && !addr[ADDR_W-1])) begin
                n_fail++;
                $display("FAIL ram_write a=%h we=%b: got %b", addr, writeEnable, RAM_write);
            end
            n_checks++;
            if (SD_cmd_valid !== cur_valid) begin
                n_fail++;
                $display("FAIL cmd_valid t=%0t: got %b, expected %b", $time, SD_cmd_valid, cur_valid);
            end
            n_checks++;
            if (SD_cmd !== cur_cmd) begin
                n_fail++;
                $display("FAIL cmd_pins t=%0t: got %h, expected %h", $time, SD_cmd, cur_cmd);
            end
            if (resetn && readEnable) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read a=%h: got %h, no expected value queued", addr, dataOut);
                end else begin
                    e = exp_q.pop_front();
                    if (dataOut !== e.v || addr !== e.a) begin
                        n_fail++;
                        $display("FAIL read a=%h: got %h, expected %h", e.a, dataOut, e.v);
                    end
                end
            end
            if (resetn && SD_cmd_valid && SD_cmd_ready) begin
                n_checks++;
                if (cmd_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_accept: got %h, no command expected", SD_cmd);
                end else begin
                    c = cmd_exp.pop_front();
                    if (SD_cmd !== c) begin
                        n_fail++;
                        $display("FAIL cmd_accept: got %h, expected %h", SD_cmd, c);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] din;
        logic [2:0]  idx;
        int          op;

        resetn = 1'b1;
        addr = '0; dataIn = '0; writeEnable = 1'b0; readEnable = 1'b0;
        RAM_out = 32'h1234_5678; BTN = '0; SD_resp_valid = 1'b0; SD_resp_data = '0;
        SD_cmd_ready = 1'b0;
        model_reset();
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset values
        rdc(pa(0), 32'h0); rdc(pa(1), 32'h0); rdc(pa(2), 32'h0000_00FF); rdc(pa(3), 32'h0);
        rdc(pa(4), 32'h0); rdc(pa(5), 32'h0); rdc(pa(6), 32'h0); rdc(pa(7), 32'h0);
        rdc(12'h010, 32'h1234_5678);
        wr(12'h020, 32'hCAFE_0000);           // RAM-space store

        // Buttons
        BTN = 5'b00100;
        idle(2);
        rdc(pa(0), 32'h4);
        rdc(pa(1), 32'h4);
        BTN = 5'b00000;
        idle(3);
        rdc(pa(1), 32'h4);
        wr(pa(1), 32'h4);
        rdc(pa(1), 32'h0);
        BTN = 5'b00100;
        idle(2);
        wr(pa(1), 32'h4);                     // clear lands on the edge that sets the flag
        rdc(pa(1), 32'h4);
        wr(pa(1), 32'h4);
        rdc(pa(1), 32'h0);
        BTN = 5'b00000;
        idle(3);

        // Command handshake
        wr(pa(4), 32'hDEAD_BEEF);
        wr(pa(5), 32'h8000_1234);
        rdc(pa(3), 32'h1);
        wr(pa(4), 32'h0); wr(pa(4), 32'h0); wr(pa(5), 32'h8000_5555);
        rdc(pa(4), 32'hDEAD_BEEF);
        rdc(pa(5), 32'h8000_1234);
        SD_cmd_ready = 1'b1;
        idle(1);
        SD_cmd_ready = 1'b0;
        rdc(pa(3), 32'h0);
        SD_cmd_ready = 1'b1;
        wr(pa(5), 32'h8000_0042);             // start with ready already high
        idle(1);
        SD_cmd_ready = 1'b0;
        rdc(pa(3), 32'h0);

        // FIFO fill past full
        for (int i = 1; i <= 9; i++) begin
            SD_resp_valid = 1'b1; SD_resp_data = 8'(i);
            idle(1);
        end
        SD_resp_valid = 1'b0;
        rdc(pa(3), 32'h0000_0802);
        for (int i = 1; i <= 8; i++) rdc(pa(2), 32'h8000_0000 | 32'(i));
        rdc(pa(2), 32'h0000_00FF);
        wr(pa(6), 32'h1);
        rdc(pa(3), 32'h0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            SD_resp_valid = 1'b1; SD_resp_data = 8'(8'h11 + i);
            idle(1);
        end
        SD_resp_data = 8'hAA;
        rdc(pa(2), 32'h8000_0011);
        SD_resp_valid = 1'b0;
        rdc(pa(3), 32'h0000_0800);
        repeat (8) rd(pa(2));
        rdc(pa(2), 32'h0000_00FF);

        // Empty with simultaneous push and pop, then flush racing a push
        SD_resp_valid = 1'b1; SD_resp_data = 8'h55;
        rdc(pa(2), 32'h0000_00FF);
        SD_resp_valid = 1'b0;
        rdc(pa(3), 32'h0000_0100);
        SD_resp_valid = 1'b1; SD_resp_data = 8'h66;
        wr(pa(6), 32'h2);
        SD_resp_valid = 1'b0;
        rdc(pa(3), 32'h0);

        // Reset while a command is pending
        wr(pa(4), 32'h0000_0001);
        wr(pa(5), 32'h8000_0000);
        SD_resp_valid = 1'b1; SD_resp_data = 8'h07;
        idle(1);
        SD_resp_valid = 1'b0;
        do_reset();
        rdc(pa(2), 32'h0000_00FF); rdc(pa(3), 32'h0); rdc(pa(4), 32'h0); rdc(pa(5), 32'h0);

        // Randomised traffic against the model
        for (int k = 0; k < 800; k++) begin
            RAM_out = $urandom;
            if ($urandom_range(0, 7) == 0) BTN = NUM_BTN'($urandom);
            SD_resp_valid = ($urandom_range(0, 2) == 0);
            SD_resp_data  = 8'($urandom);
            SD_cmd_ready  = ($urandom_range(0, 2) == 0);
            op  = $urandom_range(0, 9);
            idx = 3'($urandom);
            din = $urandom;
            writeEnable = 1'b0; readEnable = 1'b0;
            case (op)
                0, 1, 2, 3: begin addr = {1'b1, 8'($urandom), idx}; readEnable = 1'b1; end
                4:          begin addr = {1'b0, 11'($urandom)}; readEnable = 1'b1; end
                5, 6, 7: begin
                    addr = {1'b1, 8'($urandom), idx};
                    writeEnable = 1'b1;
                    if (idx == 3'd6) din[1] = ($urandom_range(0, 15) == 0);
                end
                8:       begin addr = {1'b0, 11'($urandom)}; writeEnable = 1'b1; end
                default: addr = {1'b0, 11'($urandom)};
            endcase
            dataIn = din;
            cycle(1'b0, 32'h0);
            if (k == 400) do_reset();
        end

        SD_resp_valid = 1'b0;
        SD_cmd_ready  = 1'b1;
        idle(3);
        done = 1'b1;
        #100;
        $display("FAIL end_timeout: monitor did not finish, required finish within 100 time units");
        $fatal(1);
    end

endmodule
